// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute stage to a word-addressed data memory. Accepts
//   byte-addressed byte/half/word loads and stores, checks alignment, range
//   and size, selects little-endian lanes, extends load data and performs
//   read-modify-write for sub-word stores (the memory writes whole words).
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_size,        request fields: store flag, size (00 b, 01 h,
//   req_unsigned, req_addr,  10 w, 11 illegal), zero-extend flag, byte
//   req_wdata                address, right-justified store data
//   resp_valid, resp_rdata,  one-cycle completion pulse with extended load
//   resp_err                 data and error flag
//   mem_we, mem_addr,        memory write strobe, word address, write word
//   mem_wdata, mem_rdata     and combinational read data of mem_addr
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE, so a single request
// is in flight. resp_valid is a one-cycle pulse with no backpressure.
module load_store_unit #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;

  // Latched request fields (the word address lives in mem_addr).
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic [31:0] word_q;  // store data, then merged RMW word; drives mem_wdata
  logic [31:0] load_q;  // extended load result, nonzero only in RESP
  logic        err_q;   // error flag, nonzero only in RESP

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request checks on the live request, evaluated at acceptance.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                            req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])           req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b0) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))        req_err = 1'b1;
  end

  // Lane selection and extension of the word read during READ.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (off_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      SZ_HALF: load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sub-word store merge: new lane(s) from the latched store data, all other
  // bytes from the word just read.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'd0: merged[7:0]   = word_q[7:0];
        2'd1: merged[15:8]  = word_q[7:0];
        2'd2: merged[23:16] = word_q[7:0];
        2'd3: merged[31:24] = word_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (size_q == SZ_HALF) begin
      if (off_q[1]) merged[31:16] = word_q[15:0];
      else          merged[15:0]  = word_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      mem_addr <= '0;
      word_q   <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            off_q    <= req_addr[1:0];
            mem_addr <= req_addr[AW+1:2];
            word_q   <= req_wdata;
            load_q   <= '0;
            err_q    <= req_err;
            if (req_err)                  state <= RESP;
            else if (!req_we)             state <= READ;
            else if (req_size == SZ_WORD) state <= WRITE;
            else                          state <= READ;
          end
        end
        READ: begin
          if (we_q) begin
            word_q <= merged;
            state  <= WRITE;
          end else begin
            word_q <= mem_rdata;
            load_q <= load_ext;
            state  <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: begin
          load_q <= '0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state alone so an async reset drops them at once.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WRITE);
  assign mem_wdata  = word_q;
  assign resp_rdata = load_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int tests_run = 0;
  int fails     = 0;
  int acc_count = 0;

  logic [32:0] exp_q[$];   // {err, rdata}
  int          lat_q[$];   // expected latency

  logic [31:0] mem    [DEPTH] = '{default: 32'h0};
  logic [31:0] shadow [DEPTH] = '{default: 32'h0};

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  always @(posedge clk) if (!rst && req_valid && req_ready) acc_count++;

  // ---------------- reference model ----------------
  function automatic void model(input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] rd, output int lat,
                                output logic [31:0] wword);
    logic [31:0] w;
    int bi;
    int idx;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    rd = 32'h0; wword = 32'h0; lat = 1;
    if (err) return;
    idx = int'(addr >> 2);
    bi  = int'(addr[1:0]);
    w   = shadow[idx];
    if (!we) begin
      lat = 2;
      if (size == 2'b00)
        rd = uns ? {24'h0, w[8*bi +: 8]} : {{24{w[8*bi+7]}}, w[8*bi +: 8]};
      else if (size == 2'b01)
        rd = uns ? {16'h0, w[8*bi +: 16]} : {{16{w[8*bi+15]}}, w[8*bi +: 16]};
      else
        rd = w;
    end else begin
      if (size == 2'b00)      begin w[8*bi +: 8]  = wdata[7:0];  lat = 3; end
      else if (size == 2'b01) begin w[8*bi +: 16] = wdata[15:0]; lat = 3; end
      else                    begin w = wdata;                   lat = 2; end
      shadow[idx] = w;
      wword = w;
    end
  endfunction

  // ---------------- driver ----------------
  // Issues one request and watches until the response; lat = 0 on timeout.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int nwr, output logic [AW-1:0] waddr,
                        output logic [31:0] wword);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = 32'h0; err = 1'b0; lat = 0; nwr = 0; waddr = '0; wword = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_we) begin nwr++; waddr = mem_addr; wword = mem_wdata; end
      if (resp_valid) begin lat = i; rd = resp_rdata; err = resp_err; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 1000", {req_ready, resp_valid, resp_err, mem_we});
    end
    tests_run++;
    if ({resp_rdata, mem_wdata, 22'(mem_addr)} !== 86'h0) begin
      fails++; $display("FAIL reset_data: rdata %h wdata %h addr %h want 0", resp_rdata, mem_wdata, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd, ww; logic err; int lat, nwr; logic [AW-1:0] wa;
    logic [32:0] e; int el;
    exp_q.push_back({1'b0, 32'h0}); lat_q.push_back(2);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, nwr, wa, ww);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    tests_run++; if ({err, rd} !== e) begin fails++; $display("FAIL wst_resp: got %h want %h", {err, rd}, e); end
    tests_run++; if (lat !== el) begin fails++; $display("FAIL wst_lat: got %0d want %0d", lat, el); end
    tests_run++; if (nwr !== 1 || wa !== 10'd4 || ww !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wst_write: n %0d addr %0d data %h want 1 4 deadbeef", nwr, wa, ww); end
    exp_q.push_back({1'b0, 32'hDEADBEEF}); lat_q.push_back(2);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nwr, wa, ww);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    tests_run++; if ({err, rd} !== e) begin fails++; $display("FAIL wld_resp: got %h want %h", {err, rd}, e); end
    tests_run++; if (lat !== el || nwr !== 0) begin fails++; $display("FAIL wld_lat: lat %0d n %0d want %0d 0", lat, nwr, el); end
  endtask

  task automatic test_byte_rmw;
    logic [31:0] rd, ww; logic err; int lat, nwr; logic [AW-1:0] wa;
    logic [32:0] e; int el;
    exp_q.push_back({1'b0, 32'h0}); lat_q.push_back(3);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAAAA55, rd, err, lat, nwr, wa, ww);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    tests_run++; if ({err, rd} !== e) begin fails++; $display("FAIL rmw_resp: got %h want %h", {err, rd}, e); end
    tests_run++; if (lat !== el) begin fails++; $display("FAIL rmw_lat: got %0d want %0d", lat, el); end
    tests_run++; if (nwr !== 1 || wa !== 10'd4 || ww !== 32'hDE55BEEF) begin
      fails++; $display("FAIL rmw_write: n %0d addr %0d data %h want 1 4 de55beef", nwr, wa, ww); end
  endtask

  task automatic test_sign_ext;
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DE55};
    logic [31:0] rd, ww; logic err; int lat, nwr; logic [AW-1:0] wa;
    logic [32:0] e; int el;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, ex[k]}); lat_q.push_back(2);
      do_req(1'b0, sz[k], un[k], ad[k], 32'h0, rd, err, lat, nwr, wa, ww);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      tests_run++; if ({err, rd} !== e || lat !== el) begin
        fails++; $display("FAIL ext_%0d: got %h lat %0d want %h lat %0d", k, {err, rd}, lat, e, el); end
    end
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] ad [4] = '{32'h11, 32'h0E, 32'h1000, 32'h10};
    logic [31:0] rd, ww; logic err; int lat, nwr; logic [AW-1:0] wa;
    logic [32:0] e; int el;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b1, 32'h0}); lat_q.push_back(1);
      do_req(we[k], sz[k], 1'b0, ad[k], 32'h12345678, rd, err, lat, nwr, wa, ww);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      tests_run++; if ({err, rd} !== e || lat !== el || nwr !== 0) begin
        fails++; $display("FAIL err_%0d: got %h lat %0d writes %0d want %h lat %0d writes 0", k, {err, rd}, lat, nwr, e, el); end
    end
    tests_run++; if (mem[4] !== 32'hDE55BEEF) begin
      fails++; $display("FAIL err_nowrite: mem[4] %h want de55beef", mem[4]); end
  endtask

  task automatic test_back_to_back;
    logic        we [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [3] = '{2'b10, 2'b10, 2'b00};
    logic [31:0] ad [3] = '{32'h20, 32'h20, 32'h21};
    int base, got;
    base = acc_count; got = 0;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hCAFE1234});
    exp_q.push_back({1'b0, 32'h00000012});
    fork
      begin
        int guard;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k > 0) begin
            tests_run++; if (req_ready !== 1'b0) begin
              fails++; $display("FAIL b2b_ready_%0d: got %b want 0", k, req_ready); end
          end
          req_we = we[k]; req_size = sz[k]; req_unsigned = 1'b1;
          req_addr = ad[k]; req_wdata = 32'hCAFE1234; req_valid = 1'b1;
          guard = 0;
          while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
          @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
      end
      begin
        logic [32:0] e;
        for (int c = 0; c < 60 && got < 3; c++) begin
          @(negedge clk);
          if (resp_valid) begin
            e = exp_q.pop_front();
            tests_run++; if ({resp_err, resp_rdata} !== e) begin
              fails++; $display("FAIL b2b_resp_%0d: got %h want %h", got, {resp_err, resp_rdata}, e); end
            got++;
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    tests_run++; if (got !== 3 || acc_count - base !== 3) begin
      fails++; $display("FAIL b2b_count: resps %0d accepts %0d want 3 3", got, acc_count - base); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd, ww; logic err; int lat, nwr; logic [AW-1:0] wa;
    int seen;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== '0) begin
      fails++; $display("FAIL rst_mid: ready %b we %b rv %b addr %0d want 1 0 0 0", req_ready, mem_we, resp_valid, mem_addr); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (resp_valid || mem_we) seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid || mem_we) seen++; end
    tests_run++; if (seen !== 0) begin fails++; $display("FAIL rst_quiet: got %0d events want 0", seen); end
    exp_q.push_back({1'b0, 32'hDE55BEEF}); lat_q.push_back(2);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nwr, wa, ww);
    tests_run++; if ({err, rd} !== exp_q.pop_front() || lat !== lat_q.pop_front()) begin
      fails++; $display("FAIL rst_readback: got %h lat %0d want 0de55beef lat 2", {err, rd}, lat); end
  endtask

  task automatic test_random;
    logic we, uns, merr; logic [1:0] sz; logic [31:0] ad, wd, mrd, mww;
    logic [31:0] rd, ww; logic err; int lat, nwr, mlat; logic [AW-1:0] wa;
    logic [32:0] e; int el;
    for (int k = 0; k < 40; k++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      ad  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                        : 32'h100 + $urandom_range(0, 31);
      wd  = $urandom;
      model(we, sz, uns, ad, wd, merr, mrd, mlat, mww);
      exp_q.push_back({merr, mrd}); lat_q.push_back(mlat);
      do_req(we, sz, uns, ad, wd, rd, err, lat, nwr, wa, ww);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      tests_run++; if ({err, rd} !== e || lat !== el) begin
        fails++; $display("FAIL rnd_%0d: we %b sz %0d addr %h got %h lat %0d want %h lat %0d", k, we, sz, ad, {err, rd}, lat, e, el); end
      tests_run++; if (nwr !== ((we && !merr) ? 1 : 0) || (nwr == 1 && ww !== mww)) begin
        fails++; $display("FAIL rnd_wr_%0d: writes %0d data %h want %0d %h", k, nwr, ww, (we && !merr) ? 1 : 0, mww); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sign_ext();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-addressed data memory.
- Accepts byte-addressed load/store requests of byte, half or word size.
- Performs alignment and range checks, little-endian lane selection and sign/zero extension for loads.
- Sub-word stores use read-modify-write, because the memory writes whole words only. Memory reads are combinational; memory writes take effect at the clock edge.

Parameters:
- DEPTH, 1024, data memory depth in 32-bit words.
- AW, $clog2(DEPTH), memory word-address width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned / out-of-range / illegal size; valid with resp_valid
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  word address, req_addr[AW+1:2] latched
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read of mem_addr

Behaviour:
- Reset values:
  - state = IDLE; all latched request fields = 0.
  - req_ready = 1; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, READ, WRITE, RESP.
- Handshake: a request is accepted on a rising edge where req_valid and req_ready are both 1. All request fields are latched at that edge. No new request is accepted until the unit returns to IDLE.
- Error check at acceptance:
  - Errors: req_size == 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[31:2] >= DEPTH.
  - Error transition: IDLE -> RESP with resp_err = 1. The memory is never written for an errored request.
- Transitions for legal requests:
  - load: IDLE -> READ -> RESP
  - word store: IDLE -> WRITE -> RESP
  - byte/half store: IDLE -> READ -> WRITE -> RESP
  - RESP -> IDLE unconditionally.
- READ: mem_rdata is captured into the internal word buffer at the end of the cycle.
  - Loads: the selected lane is extended and registered into the response.
  - Stores: the new lane(s) are merged into the buffer; all other bytes are preserved.
- WRITE: mem_we = 1 for exactly this one cycle; mem_wdata = merged buffer (word store: req_wdata unchanged).
- mem_we is decoded from state only, so it is never high outside WRITE.
- RESP: resp_valid = 1 for exactly one cycle with no backpressure; resp_rdata and resp_err are 0 outside RESP.
- Latency from the acceptance edge to the resp_valid cycle:
  - error: 1 cycle
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0]
  - half uses bytes addr[1]*2 .. addr[1]*2+1
- Store data source: byte uses req_wdata[7:0]; half uses req_wdata[15:0]; upper bits of req_wdata are ignored.
- Load extension replicates bit 7 (byte) or bit 15 (half) when req_unsigned = 0; word loads are not extended.
- req_ready = 1 only in IDLE, so back-to-back requests have a minimum 1-cycle gap: the RESP cycle precedes the next IDLE.
- Reset mid-operation: the state returns to IDLE immediately and asynchronously, and mem_we drops without waiting for a clock. An interrupted store produces no write and no response.
- mem_addr holds its last latched value while in IDLE; it is 0 only after reset.

Test Plan:
- Word store then load:
  - store 0xDEADBEEF at addr 0x10 -> mem_we for one cycle with mem_addr = 4, resp_valid 2 cycles after acceptance.
  - load word at 0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0, 2-cycle latency.
- Byte RMW store: with word 4 = 0xDEADBEEF, store byte 0x55 at 0x12 -> exactly one write, mem_wdata = 0xDE55BEEF, resp_valid 3 cycles after acceptance.
- Signed vs unsigned loads, word 4 = 0xDE55BEEF:
  - byte @0x13, signed -> 0xFFFFFFDE
  - byte @0x13, unsigned -> 0x000000DE
  - half @0x10, signed -> 0xFFFFBEEF
  - half @0x12, unsigned -> 0x0000DE55
- Errors: half store @0x11, word load @0x0E, any access @0x1000 (DEPTH = 1024), size 11 -> each gives resp_err = 1 one cycle after acceptance, resp_rdata = 0, and mem_we never asserts.
- Handshake: req_valid held high for three requests -> req_ready low from acceptance until IDLE, each request accepted exactly once, responses in request order.
- Reset during READ of a byte store: assert rst mid-cycle -> req_ready = 1 and mem_we = 0 immediately, no resp_valid, target word unchanged on readback.
